// File: rtl/imm_gen_pipe.sv
// Immediate generator for dispatch: decodes the RISC-V immediate from instr[31:7]
// and queues it with its tag in a 2-entry ready/valid output buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_data,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Immediate decode (combinational, written into the buffer on push)
  // ---------------------------------------------------------------------------
  logic signed [11:0] i_s, s_s;
  logic signed [12:0] b_s;
  logic signed [20:0] j_s;
  logic signed [31:0] u_s;
  logic [SH_W-1:0]    shamt;
  logic [4:0]         zimm;
  entry_t             new_ent;

  assign i_s   = in_data[24:13];
  assign s_s   = {in_data[24:18], in_data[4:0]};
  assign b_s   = {in_data[24], in_data[0], in_data[23:18], in_data[4:1], 1'b0};
  assign j_s   = {in_data[24], in_data[12:5], in_data[13], in_data[23:14], 1'b0};
  assign u_s   = {in_data[24:5], 12'b0};
  assign shamt = in_data[13+SH_W-1:13];
  assign zimm  = in_data[12:8];

  always_comb begin
    new_ent     = '0;
    new_ent.tag = in_tag;
    case (in_type)
      3'b000:  new_ent.imm = XLEN'(i_s);
      3'b001:  new_ent.imm = XLEN'(shamt);
      3'b010:  new_ent.imm = XLEN'(s_s);
      3'b011:  new_ent.imm = XLEN'(b_s);
      3'b100:  new_ent.imm = XLEN'(j_s);
      3'b101:  new_ent.imm = XLEN'(u_s);
      3'b110:  new_ent.imm = XLEN'(zimm);
      default: new_ent.err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output buffer: state is the occupancy count
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             rptr_q, rptr_d, wptr_q, wptr_d;
  entry_t           mem_q [2];
  logic [CNT_W-1:0] err_q, err_d;
  logic             push, pop;

  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (flush) begin
      state_d = EMPTY;
      rptr_d  = 1'b0;
      wptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (push & ~pop) state_d = FULL;
                 else if (pop & ~push) state_d = EMPTY;
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (push && new_ent.err && err_q != '1) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= new_ent;
    end
  end

  entry_t head;
  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rptr_q];
  end

  assign out_imm   = head.imm;
  assign out_tag   = head.tag;
  assign out_err   = head.err;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives an XLEN=32/CNT_W=2 and an XLEN=64/CNT_W=8 instance in lockstep and
// scoreboards both against a RISC-V-level immediate model.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [24:0] in_data = '0;
  logic [2:0]  in_type = '0;
  logic [5:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, rdy64, vld32, vld64, err32, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [5:0]  tag32, tag64;
  logic [1:0]  cnt32;
  logic [7:0]  cnt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(6), .CNT_W(2)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_data(in_data), .in_type(in_type), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_err(err32),
    .err_count(cnt32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(6), .CNT_W(8)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_data(in_data), .in_type(in_type), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_err(err64),
    .err_count(cnt64));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    longint top;
    top = longint'(1) << (w - 1);
    return (v ^ top) - top;
  endfunction

  // Immediate derived from the full instruction word using RISC-V field positions.
  function automatic logic [63:0] ref_imm(input logic [24:0] d, input logic [2:0] t, input int xlen);
    logic [31:0] ins;
    longint v;
    ins = {d, 7'b0};
    case (t)
      3'd0: v = sx(longint'(ins[31:20]), 12);
      3'd1: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd2: v = sx(longint'({ins[31:25], ins[11:7]}), 12);
      3'd3: v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      3'd4: v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      3'd5: v = sx(longint'({ins[31:12], 12'b0}), 32);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [5:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_ill = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic push, pop, mrdy;
    if (!rst_n) begin
      sb.delete();
      n_ill = 0;
    end else begin
      mrdy = (sb.size() < 2) && !flush;
      chk("in_ready32", rdy32, mrdy);
      chk("in_ready64", rdy64, mrdy);
      chk("out_valid32", vld32, sb.size() != 0);
      chk("out_valid64", vld64, sb.size() != 0);
      chk("err_count32", cnt32, (n_ill > 3) ? 3 : n_ill);
      chk("err_count64", cnt64, (n_ill > 255) ? 255 : n_ill);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("imm32", imm32, e.i32);
        chk("imm64", imm64, e.i64);
        chk("tag32", tag32, e.tag);
        chk("tag64", tag64, e.tag);
        chk("err32", err32, e.err);
        chk("err64", err64, e.err);
      end else begin
        chk("idle_out32", {imm32, tag32, err32}, 0);
        chk("idle_out64", {imm64[31:0], tag64, err64}, 0);
      end
      pop  = out_ready && (sb.size() != 0);
      push = in_valid && mrdy;
      if (flush) sb.delete();
      else begin
        if (pop) void'(sb.pop_front());
        if (push) begin
          e.i32 = ref_imm(in_data, in_type, 32);
          e.i64 = ref_imm(in_data, in_type, 64);
          e.tag = in_tag;
          e.err = (in_type == 3'd7);
          sb.push_back(e);
          if (e.err) n_ill++;
        end
      end
    end
  end

  task automatic send(input logic [24:0] d, input logic [2:0] t, input logic [5:0] tg);
    int n;
    in_valid = 1'b1; in_data = d; in_type = t; in_tag = tg;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy32) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_vld", {vld32, vld64}, 0);
    chk("rst_out", {imm32, imm64, tag32, tag64, err32, err64}, 0);
    chk("rst_cnt", {cnt32, cnt64}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // sign-extended all-ones I immediate
    out_ready = 1'b1;
    send(25'h1FFE000, 3'd0, 6'd9);
    @(negedge clk);
    chk("t1_vld", vld32, 1);
    chk("t1_imm32", imm32, 32'hFFFF_FFFF);
    chk("t1_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(2);

    // shamt width depends on XLEN
    send(25'h007E000, 3'd1, 6'd10);
    @(negedge clk);
    chk("t2_imm32", imm32, 32'h1F);
    chk("t2_imm64", imm64, 64'h3F);
    tick(2);

    // backpressure: third word held until consumer opens
    out_ready = 1'b0;
    fork
      begin
        send(25'h1234567, 3'd2, 6'd1);
        send(25'h0ABCDEF, 3'd3, 6'd2);
        send(25'h1555555, 3'd4, 6'd3);
      end
      begin
        tick(6);
        out_ready = 1'b1;
      end
    join
    tick(4);

    // simultaneous push/pop with one entry
    out_ready = 1'b0;
    send(25'h0F0F0F0, 3'd5, 6'd4);
    out_ready = 1'b1;
    send(25'h1F00000, 3'd6, 6'd5);
    tick(3);

    // flush while full drops the incoming word
    out_ready = 1'b0;
    send(25'h0000001, 3'd0, 6'd6);
    send(25'h0000002, 3'd0, 6'd7);
    flush = 1'b1; in_valid = 1'b1; in_data = 25'h1ABCDEF; in_tag = 6'd8;
    tick(1);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_vld", vld32, 0);
    chk("t5_imm", imm64, 0);
    tick(3);

    // illegal format and counter saturation
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(25'(k * 77), 3'd7, 6'(20 + k));
    tick(2);
    @(negedge clk);
    chk("t6_cnt32", cnt32, 3);
    chk("t6_cnt64", cnt64, 5);

    // async reset mid-stream
    tick(1);
    out_ready = 1'b0;
    send(25'h1111111, 3'd3, 6'd30);
    send(25'h0222222, 3'd4, 6'd31);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst2_vld", {vld32, vld64}, 0);
    chk("rst2_out", {imm32, imm64, tag32, tag64, err32, err64}, 0);
    chk("rst2_cnt", {cnt32, cnt64}, 0);
    tick(2);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick(1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 25'($urandom);
      in_type   = 3'($urandom_range(0, 7));
      in_tag    = 6'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(4);
    @(negedge clk);
    chk("drain_vld", vld32, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
